// File: rtl/sprite_pkg.sv
// Shared constants, state encoding and window helper for the sprite animation controller.
package sprite_pkg;

  localparam int          SPRITE_DIM  = 64;
  localparam logic [11:0] TRANSPARENT = 12'hFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } anim_state_t;

  // A signed 11-bit offset lies inside the sprite when it is 0..SPRITE_DIM-1.
  function automatic logic in_span(input logic [10:0] d);
    return (d[10] == 1'b0) && (d < 11'(SPRITE_DIM));
  endfunction

endpackage

// File: rtl/sprite_frame_timer.sv
// Divides frame_tick pulses: step fires on the enabled tick that completes a frame period.
import sprite_pkg::*;

module sprite_frame_timer #(
  parameter int TICKS_PER_FRAME = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic step
);

  localparam logic [7:0] LAST_TICK = 8'(TICKS_PER_FRAME - 1);

  logic [7:0] tick_cnt;

  assign step = enable && (tick_cnt == LAST_TICK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= 8'd0;
    end else if (clear) begin
      tick_cnt <= 8'd0;
    end else if (enable) begin
      tick_cnt <= step ? 8'd0 : tick_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/sprite_anim_ctrl.sv
// Sprite animation sequencer and two-stage pixel front-end for the 64x64 frame ROMs.
// Optional horizontal mirroring is compiled in with `define SPRITE_MIRROR_EN.
import sprite_pkg::*;

module sprite_anim_ctrl #(
  parameter int NUM_FRAMES      = 11,
  parameter int TICKS_PER_FRAME = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        stop,
  input  logic        pause,
  input  logic        loop,
  input  logic        flip_h,
  input  logic        video_on,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  output logic [5:0]  rom_row,
  output logic [5:0]  rom_col,
  input  logic [11:0] rom_color,
  output logic [3:0]  frame_sel,
  output logic [11:0] pixel_out,
  output logic        pixel_valid,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] LAST_FRAME = 4'(NUM_FRAMES - 1);

  anim_state_t state, state_next;
  logic [3:0]  frame_next;
  logic        done_next;
  logic        timer_clear;
  logic        timer_en;
  logic        step;

  // The divider only counts real ticks while playing; start/stop pre-empt the tick.
  assign timer_clear = stop | start;
  assign timer_en    = (state == PLAY) && !pause && !stop && !start && frame_tick;

  sprite_frame_timer #(
    .TICKS_PER_FRAME(TICKS_PER_FRAME)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .enable(timer_en),
    .step  (step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      frame_sel <= 4'd0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      frame_sel <= frame_next;
      done      <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    frame_next = frame_sel;
    done_next  = 1'b0;
    if (stop) begin
      state_next = IDLE;
      frame_next = 4'd0;
    end else if (start) begin
      state_next = PLAY;
      frame_next = 4'd0;
    end else begin
      case (state)
        PLAY: begin
          if (pause) begin
            state_next = HOLD;
          end else if (step) begin
            if (frame_sel != LAST_FRAME) begin
              frame_next = frame_sel + 4'd1;
            end else if (loop) begin
              frame_next = 4'd0;
            end else begin
              state_next = DONE;
              done_next  = 1'b1;
            end
          end
        end
        HOLD: begin
          if (!pause) state_next = PLAY;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == PLAY) || (state == HOLD);

  logic [10:0] dx, dy;
  logic        in_win;
  logic        in_win_d, video_on_d;

  assign dx      = {1'b0, pixel_x} - {1'b0, sprite_x};
  assign dy      = {1'b0, pixel_y} - {1'b0, sprite_y};
  assign in_win  = in_span(dx) && in_span(dy);
  assign rom_row = dy[5:0];

`ifdef SPRITE_MIRROR_EN
  // 63 - col is the bitwise complement of a 6-bit column.
  assign rom_col = flip_h ? ~dx[5:0] : dx[5:0];
`else
  logic unused_flip_h;
  assign unused_flip_h = flip_h;
  assign rom_col       = dx[5:0];
`endif

  // Window/visibility are delayed one stage to line up with the ROM read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_win_d    <= 1'b0;
      video_on_d  <= 1'b0;
      pixel_out   <= TRANSPARENT;
      pixel_valid <= 1'b0;
    end else begin
      in_win_d   <= in_win;
      video_on_d <= video_on;
      if (in_win_d && video_on_d && (rom_color != TRANSPARENT)) begin
        pixel_out   <= rom_color;
        pixel_valid <= 1'b1;
      end else begin
        pixel_out   <= TRANSPARENT;
        pixel_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/sprite_anim_ctrl.md
# sprite_anim_ctrl

Animation sequencer and pixel front-end for the 64x64 sprite frame ROMs. It steps a frame index through the animation at a programmable number of vertical-sync ticks per frame, and converts the VGA scan position into ROM row/column addresses. It re-aligns the one-cycle ROM read latency and emits a registered sprite pixel with an opacity flag to the top-level colour mux.

## Interface
Parameters:
- NUM_FRAMES, 11, number of animation frames (frame0..frame10); frame_sel counts 0..NUM_FRAMES-1.
- TICKS_PER_FRAME, 6, frame_tick pulses per animation step; legal range 1..255.

Ports:
- clk  in  1  system/pixel clock.
- reset  in  1  asynchronous, active-high.
- frame_tick  in  1  one-cycle pulse at start of vertical blank.
- start  in  1  pulse: restart animation at frame 0.
- stop  in  1  pulse: abort, return to IDLE.
- pause  in  1  level: freeze on current frame while high.
- loop  in  1  level: wrap to frame 0 after last frame instead of finishing.
- flip_h  in  1  horizontal mirror request (see Configuration).
- video_on  in  1  scan position is in the visible area.
- pixel_x, pixel_y  in  10 each  current scan position.
- sprite_x, sprite_y  in  10 each  sprite top-left corner on screen.
- rom_row, rom_col  out  6 each  ROM address, combinational from scan inputs.
- rom_color  in  12  selected ROM color_val, valid one cycle after address.
- frame_sel  out  4  frame index driving the external ROM mux.
- pixel_out  out  12  registered sprite colour.
- pixel_valid  out  1  registered: in window, video_on, and opaque.
- busy  out  1  high in PLAY or HOLD.
- done  out  1  one-cycle pulse on completion of a non-looping run.

## Operation
- States: IDLE, PLAY, HOLD, DONE.
- IDLE: frame_sel=0, tick_cnt=0. start -> PLAY.
- PLAY: each frame_tick increments tick_cnt. At tick_cnt==TICKS_PER_FRAME-1, tick_cnt clears and the frame advances. At the last frame with loop=1, the frame wraps to 0. At the last frame with loop=0, go to DONE, frame_sel holds NUM_FRAMES-1, done pulses.
- PLAY and pause=1 -> HOLD. HOLD ignores frame_tick. HOLD and pause=0 -> PLAY, and tick_cnt resumes where it stopped.
- DONE: holds the last frame. start -> PLAY.
- start in any state: frame_sel=0, tick_cnt=0, go to PLAY.
- stop in any state: go to IDLE.
- Priority: stop > start > frame_tick. When start and frame_tick coincide, the tick is discarded.
- frame_sel changes only on a frame_tick edge or on start/stop. A frame therefore never changes mid-scanline during an active run.
- Window: dx = pixel_x - sprite_x and dy = pixel_y - sprite_y, both computed 11-bit signed. The pixel is in-window iff 0 <= dx,dy <= 63.
- rom_col = dx[5:0], rom_row = dy[5:0]. Outside the window the address is don't-care.
- A sprite that extends past the screen edge is clipped. There is no wrap-around.
- Transparent colour is 12'hFFF (the ROM default).
- Output rule: pixel_valid = in_win_d & video_on_d & (rom_color != 12'hFFF). When pixel_valid=0, pixel_out = 12'hFFF.

## Timing
- Reset values: frame_sel=0, pixel_out=12'hFFF, pixel_valid=0, busy=0, done=0, state IDLE, tick_cnt=0.
- Pixel latency is 2 cycles:
  - cycle N: scan inputs are applied; rom_row/rom_col are driven.
  - edge N+1: the ROM registers the address, and in_win/video_on are delayed by one stage.
  - edge N+2: pixel_out and pixel_valid are registered.
- Control latency: frame_sel/busy update on the edge that samples start/stop/frame_tick. done is high exactly the cycle after that edge.
- Reset asserted mid-run: all registers return to reset values immediately (async). Operation resumes only on a new start.

## Configuration
- SPRITE_MIRROR_EN defined: when flip_h=1, rom_col = 63 - dx[5:0]. flip_h is sampled with the scan inputs.
- SPRITE_MIRROR_EN undefined: the flip_h port still exists but is ignored, and rom_col = dx[5:0].

## Structure
- Package sprite_pkg holds:
  - SPRITE_DIM=64
  - TRANSPARENT=12'hFFF
  - the state encoding (IDLE=0, PLAY=1, HOLD=2, DONE=3)
- One sub-module, sprite_frame_timer: the tick_cnt divider with clear/enable, producing a step pulse.

## Test plan
- Run, no loop: NUM_FRAMES=11, TICKS_PER_FRAME=6, start, then 66 frame_ticks.
  - Expect frame_sel to step 0..10 every 6 ticks.
  - Expect done to pulse once, after the 66th tick, with frame_sel=10 and busy=0.
- Run with loop=1: after 66 ticks frame_sel=0 and busy=1, with no done pulse.
- Pause: pause=1 at frame 3, then 20 frame_ticks.
  - frame_sel must stay 3.
  - After release, the next step needs the remaining ticks only.
- Window: sprite_x=100, sprite_y=50, scan (110,60).
  - Expect rom_row=10, rom_col=10.
  - With rom_color=12'h0D1 presented one cycle later, pixel_out=12'h0D1 and pixel_valid=1 two cycles after the scan.
  - With rom_color=12'hFFF, pixel_valid=0.
  - At scan (164,60), dx=64: pixel_valid=0.
- Priority: stop, start and frame_tick in the same cycle -> IDLE, frame_sel=0. Async reset mid-PLAY -> all outputs at reset values in the same cycle.
- Mirror (SPRITE_MIRROR_EN defined): flip_h=1 with dx=10 -> rom_col=53. Without the macro -> rom_col=10.
